// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared types and constants for the CPU-to-AXI3 bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

  typedef logic [1:0] rd_state_t;
  typedef logic [1:0] wr_state_t;

  localparam rd_state_t R_IDLE = 2'd0;
  localparam rd_state_t R_AR   = 2'd1;
  localparam rd_state_t R_R    = 2'd2;

  localparam wr_state_t W_IDLE = 2'd0;
  localparam wr_state_t W_REQ  = 2'd1;
  localparam wr_state_t W_B    = 2'd2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] ID_INST        = 4'd0;
  localparam logic [3:0] ID_DATA        = 4'd1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // SRAM-side size codes map directly onto AXI byte-count exponents.
  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cpu_axi_bridge
// Description : Merges the CPU's instruction and data SRAM-like ports onto one
//               AXI3 master with one read FSM and one write FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_axi_bridge
  import axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_t   r_rd_state;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;

  wr_state_t   r_wr_state;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  logic w_rd_idle;
  logic w_wr_idle;
  logic w_data_rd_inflight;
  logic w_data_rd_acc;
  logic w_inst_rd_acc;
  logic w_data_wr_acc;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_r_hs;
  logic w_b_hs;
  logic w_unused;

  assign w_rd_idle          = (r_rd_state == R_IDLE);
  assign w_wr_idle          = (r_wr_state == W_IDLE);
  assign w_data_rd_inflight = !w_rd_idle && (r_arid == ID_DATA);

  // Reads wait for an idle write side so they never overtake a pending store;
  // the data port has priority over instruction fetch.
  assign w_data_rd_acc = data_sram_req && !data_sram_wr && w_rd_idle && w_wr_idle;
  assign w_inst_rd_acc = inst_sram_req && !data_sram_req && w_rd_idle && w_wr_idle;
  assign w_data_wr_acc = data_sram_req && data_sram_wr && w_wr_idle && !w_data_rd_inflight;

  assign inst_sram_addr_ok = w_inst_rd_acc;
  assign data_sram_addr_ok = w_data_rd_acc || w_data_wr_acc;

  assign arvalid = (r_rd_state == R_AR);
  assign rready  = (r_rd_state == R_R);
  assign awvalid = (r_wr_state == W_REQ) && !r_aw_done;
  assign wvalid  = (r_wr_state == W_REQ) && !r_w_done;
  assign bready  = (r_wr_state == W_B);

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_r_hs  = rvalid && rready;
  assign w_b_hs  = bvalid && bready;

  assign inst_sram_data_ok = w_r_hs && (rid == ID_INST);
  assign data_sram_data_ok = (w_r_hs && (rid == ID_DATA)) || w_b_hs;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arlen   = 4'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = ID_DATA;
  assign awaddr  = r_awaddr;
  assign awsize  = r_awsize;
  assign awlen   = 4'd0;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid   = ID_DATA;
  assign wdata = r_wdata;
  assign wstrb = r_wstrb;
  assign wlast = 1'b1;

  assign w_unused = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                      rresp, rlast, bid, bresp};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_arid     <= ID_INST;
      r_araddr   <= 32'd0;
      r_arsize   <= 3'd0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_data_rd_acc) begin
            r_rd_state <= R_AR;
            r_arid     <= ID_DATA;
            r_araddr   <= data_sram_addr;
            r_arsize   <= axi_size(data_sram_size);
          end else if (w_inst_rd_acc) begin
            r_rd_state <= R_AR;
            r_arid     <= ID_INST;
            r_araddr   <= inst_sram_addr;
            r_arsize   <= axi_size(inst_sram_size);
          end
        end
        R_AR:    if (arready) r_rd_state <= R_R;
        R_R:     if (rvalid)  r_rd_state <= R_IDLE;
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= W_IDLE;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awaddr   <= 32'd0;
      r_awsize   <= 3'd0;
      r_wstrb    <= 4'd0;
      r_wdata    <= 32'd0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_data_wr_acc) begin
            r_wr_state <= W_REQ;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awaddr   <= data_sram_addr;
            r_awsize   <= axi_size(data_sram_size);
            r_wstrb    <= data_sram_wstrb;
            r_wdata    <= data_sram_wdata;
          end
        end
        W_REQ: begin
          // Address and data channels complete independently, in either order.
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_wr_state <= W_B;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
          end
        end
        W_B:     if (bvalid) r_wr_state <= W_IDLE;
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_axi_bridge
// Description : Directed bench for cpu_axi_bridge with a transaction-level
//               reference model checked every cycle on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding read (owner port + AR-done flag) and one
  // outstanding write (AW/W done flags), tracked at transaction level.
  bit          m_rd_busy, m_rd_port, m_ar_done;
  logic [31:0] m_rd_addr;
  logic [2:0]  m_rd_size;
  bit          m_wr_busy, m_aw_done, m_w_done;
  logic [31:0] m_wr_addr, m_wr_data;
  logic [2:0]  m_wr_size;
  logic [3:0]  m_wr_strb;

  always @(negedge clk) begin
    bit e_rd_free, e_drd, e_dwr, e_ird;
    bit e_arv, e_rr, e_awv, e_wv, e_br, rfire, bfire;
    e_rd_free = !m_rd_busy && !m_wr_busy;
    e_drd = data_sram_req && !data_sram_wr && e_rd_free;
    e_dwr = data_sram_req && data_sram_wr && !m_wr_busy && !(m_rd_busy && m_rd_port);
    e_ird = inst_sram_req && !data_sram_req && e_rd_free;
    e_arv = m_rd_busy && !m_ar_done;
    e_rr  = m_rd_busy && m_ar_done;
    e_awv = m_wr_busy && !m_aw_done;
    e_wv  = m_wr_busy && !m_w_done;
    e_br  = m_wr_busy && m_aw_done && m_w_done;
    rfire = rvalid && e_rr;
    bfire = bvalid && e_br;

    chk("inst_addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, e_ird});
    chk("data_addr_ok", {31'd0, data_sram_addr_ok}, {31'd0, e_drd || e_dwr});
    chk("arvalid", {31'd0, arvalid}, {31'd0, e_arv});
    chk("rready",  {31'd0, rready},  {31'd0, e_rr});
    chk("awvalid", {31'd0, awvalid}, {31'd0, e_awv});
    chk("wvalid",  {31'd0, wvalid},  {31'd0, e_wv});
    chk("bready",  {31'd0, bready},  {31'd0, e_br});
    chk("inst_data_ok", {31'd0, inst_sram_data_ok}, {31'd0, rfire && rid == 4'd0});
    chk("data_data_ok", {31'd0, data_sram_data_ok},
        {31'd0, (rfire && rid == 4'd1) || bfire});
    chk("inst_rdata", inst_sram_rdata, rdata);
    chk("data_rdata", data_sram_rdata, rdata);
    if (e_arv) begin
      chk("araddr", araddr, m_rd_addr);
      chk("arsize", {29'd0, arsize}, {29'd0, m_rd_size});
      chk("arid", {28'd0, arid}, {31'd0, m_rd_port});
      chk("arburst", {30'd0, arburst}, 32'd1);
      chk("arlen", {28'd0, arlen}, 32'd0);
    end
    if (e_awv) begin
      chk("awaddr", awaddr, m_wr_addr);
      chk("awsize", {29'd0, awsize}, {29'd0, m_wr_size});
      chk("awid", {28'd0, awid}, 32'd1);
      chk("awburst", {30'd0, awburst}, 32'd1);
    end
    if (e_wv) begin
      chk("wdata", wdata, m_wr_data);
      chk("wstrb", {28'd0, wstrb}, {28'd0, m_wr_strb});
      chk("wlast", {31'd0, wlast}, 32'd1);
      chk("wid", {28'd0, wid}, 32'd1);
    end

    if (reset) begin
      m_rd_busy = 0; m_ar_done = 0; m_wr_busy = 0; m_aw_done = 0; m_w_done = 0;
    end else begin
      if (rfire) m_rd_busy = 0;
      else if (e_arv && arready) m_ar_done = 1;
      if (bfire) m_wr_busy = 0;
      else begin
        if (e_awv && awready) m_aw_done = 1;
        if (e_wv && wready) m_w_done = 1;
      end
      if (e_drd || e_ird) begin
        m_rd_busy = 1; m_ar_done = 0; m_rd_port = e_drd;
        m_rd_addr = e_drd ? data_sram_addr : inst_sram_addr;
        m_rd_size = {1'b0, e_drd ? data_sram_size : inst_sram_size};
      end
      if (e_dwr) begin
        m_wr_busy = 1; m_aw_done = 0; m_w_done = 0;
        m_wr_addr = data_sram_addr; m_wr_size = {1'b0, data_sram_size};
        m_wr_strb = data_sram_wstrb; m_wr_data = data_sram_wdata;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd0; inst_sram_wstrb = 4'd0;
    inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd0; data_sram_wstrb = 4'd0;
    data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    arready = 0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 2'd0; bvalid = 0;
    repeat (2) tick;
    #1;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid",  {31'd0, wvalid},  32'd0);
    chk("rst_bready",  {31'd0, bready},  32'd0);
    chk("rst_araddr",  araddr, 32'd0);
    chk("rst_awaddr",  awaddr, 32'd0);
    reset = 1'b0;

    // Instruction read, zero-wait AR, R one cycle after entering the data phase
    tick; inst_sram_req = 1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1c000000;
    #1 chk("t1_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick; inst_sram_req = 0; arready = 1;
    #1 chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("t1_arid", {28'd0, arid}, 32'd0);
    chk("t1_araddr", araddr, 32'h1c000000);
    tick; arready = 0;
    tick; rvalid = 1; rid = 4'd0; rdata = 32'h02800c0c;
    #1 chk("t1_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk("t1_rdata", inst_sram_rdata, 32'h02800c0c);
    tick; rvalid = 0;

    // Simultaneous inst and data reads: data wins, inst waits for the gap
    tick; inst_sram_req = 1; inst_sram_addr = 32'h1c000004;
    data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2'd0; data_sram_addr = 32'h00000203;
    #1 chk("t2_data_ok_acc", {31'd0, data_sram_addr_ok}, 32'd1);
    chk("t2_inst_blocked", {31'd0, inst_sram_addr_ok}, 32'd0);
    tick; data_sram_req = 0; arready = 1;
    #1 chk("t2_arid", {28'd0, arid}, 32'd1);
    chk("t2_arsize", {29'd0, arsize}, 32'd0);
    tick; arready = 0;
    tick; rvalid = 1; rid = 4'd1; rdata = 32'hdeadbeef;
    #1 chk("t2_data_dok", {31'd0, data_sram_data_ok}, 32'd1);
    chk("t2_inst_wait", {31'd0, inst_sram_addr_ok}, 32'd0);
    tick; rvalid = 0;
    #1 chk("t2_inst_acc", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick; inst_sram_req = 0; arready = 1;
    tick; arready = 0;
    tick; rvalid = 1; rid = 4'd0; rdata = 32'h12345678;
    tick; rvalid = 0;

    // Data write with delayed AWREADY, then a data read parked behind W_B
    tick; data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2;
    data_sram_addr = 32'h00000100; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'ha5a5_1234;
    #1 chk("t3_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    tick; data_sram_req = 0; data_sram_wr = 0; wready = 1;
    #1 chk("t3_awaddr", awaddr, 32'h00000100);
    chk("t3_wstrb", {28'd0, wstrb}, 32'h3);
    tick; wready = 0;
    #1 chk("t3_wvalid_drop", {31'd0, wvalid}, 32'd0);
    chk("t3_awvalid_hold", {31'd0, awvalid}, 32'd1);
    tick;
    tick; awready = 1;
    #1 chk("t3_awvalid_4th", {31'd0, awvalid}, 32'd1);
    chk("t3_no_bready", {31'd0, bready}, 32'd0);
    tick; awready = 0; data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2'd1;
    data_sram_addr = 32'h00000100;
    #1 chk("t3_bready", {31'd0, bready}, 32'd1);
    chk("t4_rd_blocked", {31'd0, data_sram_addr_ok}, 32'd0);
    tick; bvalid = 1;
    #1 chk("t3_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    chk("t4_rd_blocked2", {31'd0, data_sram_addr_ok}, 32'd0);
    tick; bvalid = 0;
    #1 chk("t4_rd_acc", {31'd0, data_sram_addr_ok}, 32'd1);
    tick; data_sram_req = 0; arready = 1;
    tick; arready = 0;
    tick; rvalid = 1; rid = 4'd1; rdata = 32'h0000beef;
    tick; rvalid = 0;

    // Reset pulse while the read sits in the data phase
    tick; inst_sram_req = 1; inst_sram_addr = 32'h1c000040;
    tick; inst_sram_req = 0; arready = 1;
    tick; arready = 0; reset = 1;
    tick; reset = 0; rvalid = 1; rid = 4'd0; rdata = 32'h0badf00d;
    inst_sram_req = 1; inst_sram_addr = 32'h1c000080;
    #1 chk("t5_arvalid", {31'd0, arvalid}, 32'd0);
    chk("t5_rready", {31'd0, rready}, 32'd0);
    chk("t5_no_dok", {31'd0, inst_sram_data_ok}, 32'd0);
    chk("t5_idle", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick; inst_sram_req = 0; rvalid = 0; arready = 1;
    #1 chk("t5_araddr", araddr, 32'h1c000080);
    tick; arready = 0;
    tick; rvalid = 1; rid = 4'd0; rdata = 32'h11112222;
    tick; rvalid = 0;

    // Inst read completion and data write response in the same cycle
    tick; inst_sram_req = 1; inst_sram_addr = 32'h1c0000c0;
    tick; inst_sram_req = 0; arready = 1;
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd0;
    data_sram_addr = 32'h00000207; data_sram_wstrb = 4'b1000; data_sram_wdata = 32'h77000000;
    #1 chk("t6_wr_acc", {31'd0, data_sram_addr_ok}, 32'd1);
    tick; arready = 0; data_sram_req = 0; data_sram_wr = 0; awready = 1; wready = 1;
    tick; awready = 0; wready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h3c1c0000; bvalid = 1;
    #1 chk("t6_inst_dok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk("t6_data_dok", {31'd0, data_sram_data_ok}, 32'd1);
    tick; rvalid = 0; bvalid = 0;
    repeat (3) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
